// File: rtl/l2_home_responder_pkg.sv
// Shared types for the L2 home responder.
//   - Spandex coherence message encodings (requests and responses) and
//     their widths (MSG_BITS, INVACK_CNT_BITS).
//   - Default word/line types.
//   - hr_state_t: responder FSM state, also exported on a debug port.
//   - Helper functions classifying a request opcode.
package l2_home_responder_pkg;

    localparam int MSG_BITS        = 5;
    localparam int INVACK_CNT_BITS = 4;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] line_t;

    typedef enum logic [MSG_BITS-1:0] {
        REQ_V      = 5'd0,
        REQ_S      = 5'd1,
        REQ_WT     = 5'd2,
        REQ_O      = 5'd3,
        REQ_Odata  = 5'd4,
        REQ_WB     = 5'd5,
        RSP_V      = 5'd8,
        RSP_S      = 5'd9,
        RSP_WT     = 5'd10,
        RSP_O      = 5'd11,
        RSP_Odata  = 5'd12,
        RSP_WB_ACK = 5'd13
    } mix_msg_t;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        MEM  = 2'd2,
        RSP  = 2'd3
    } hr_state_t;

    function automatic logic msg_supported(input logic [MSG_BITS-1:0] m);
        case (m)
            REQ_V, REQ_S, REQ_WT, REQ_O, REQ_Odata, REQ_WB: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Requests whose response carries the stored line.
    function automatic logic msg_reads(input logic [MSG_BITS-1:0] m);
        case (m)
            REQ_V, REQ_S, REQ_Odata: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    // Requests that perform a masked write into the store.
    function automatic logic msg_writes(input logic [MSG_BITS-1:0] m);
        case (m)
            REQ_WT, REQ_O, REQ_Odata, REQ_WB: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic [MSG_BITS-1:0] msg_rsp(input logic [MSG_BITS-1:0] m);
        case (m)
            REQ_V:     return RSP_V;
            REQ_S:     return RSP_S;
            REQ_WT:    return RSP_WT;
            REQ_O:     return RSP_O;
            REQ_Odata: return RSP_Odata;
            REQ_WB:    return RSP_WB_ACK;
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/l2_home_responder_store.sv
// Backing store for the home responder: 2^IDX_BITS lines of
// WORDS_PER_LINE words, synchronous read, per-word write enable.
// Ports:
//   clk      clock
//   index_i  line index
//   rd_en_i  capture mem[index_i] into rdata_o at the clock edge
//   wr_en_i  write enable, qualified per word by wmask_i
//   wmask_i  word mask for writes
//   wdata_i  write data (full line; only masked words are used)
//   rdata_o  registered read data
// A read and a write to the same index in the same cycle return the data
// from before the write (read-before-write), which REQ_Odata relies on.
module l2_home_store
    import l2_home_responder_pkg::*;
#(
    parameter int WORD_BITS      = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_BITS       = 6
) (
    input  logic                                clk,
    input  logic [IDX_BITS-1:0]                 index_i,
    input  logic                                rd_en_i,
    input  logic                                wr_en_i,
    input  logic [WORDS_PER_LINE-1:0]           wmask_i,
    input  logic [WORDS_PER_LINE*WORD_BITS-1:0] wdata_i,
    output logic [WORDS_PER_LINE*WORD_BITS-1:0] rdata_o
);

    localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;
    localparam int DEPTH     = 1 << IDX_BITS;

    logic [LINE_BITS-1:0] mem_q [DEPTH];
    logic [LINE_BITS-1:0] rdata_q;

    // No reset on the array: the responder clears it line by line in INIT.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rdata_q <= mem_q[index_i];
        end
        if (wr_en_i) begin
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                if (wmask_i[w]) begin
                    mem_q[index_i][w*WORD_BITS +: WORD_BITS] <= wdata_i[w*WORD_BITS +: WORD_BITS];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_home_responder.sv
// Home-side responder for the Spandex request/response protocol. Accepts
// one request at a time from the L2 request channel, services it from a
// word-maskable backing store and returns a single response.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_in_*            request channel (valid/ready)
//   rsp_out_*           response channel (valid/ready)
//   err_pulse           one-cycle pulse after accepting an unsupported opcode
//   dbg_state_o         current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid and its payload stable until then, and
// ready never depends combinationally on valid.
// Timing: after the accepting edge the FSM spends MEM_LAT cycles counting
// down, issues the store access, and one cycle later (synchronous read)
// loads the response registers. rsp_out_valid therefore rises MEM_LAT+1
// edges after acceptance.
module l2_home_responder
    import l2_home_responder_pkg::*;
#(
    parameter int WORD_BITS      = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINE_ADDR_BITS = 28,
    parameter int IDX_BITS       = 6,
    parameter int REQ_ID_BITS    = 4,
    parameter int MEM_LAT        = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_in_valid,
    output logic                                req_in_ready,
    input  logic [MSG_BITS-1:0]                 req_in_coh_msg,
    input  logic [REQ_ID_BITS-1:0]              req_in_req_id,
    input  logic [LINE_ADDR_BITS-1:0]           req_in_addr,
    input  logic [WORDS_PER_LINE-1:0]           req_in_word_mask,
    input  logic [WORDS_PER_LINE*WORD_BITS-1:0] req_in_line,
    output logic                                rsp_out_valid,
    input  logic                                rsp_out_ready,
    output logic [MSG_BITS-1:0]                 rsp_out_coh_msg,
    output logic [REQ_ID_BITS-1:0]              rsp_out_req_id,
    output logic [LINE_ADDR_BITS-1:0]           rsp_out_addr,
    output logic [WORDS_PER_LINE-1:0]           rsp_out_word_mask,
    output logic [WORDS_PER_LINE*WORD_BITS-1:0] rsp_out_line,
    output logic [INVACK_CNT_BITS-1:0]          rsp_out_invack_cnt,
    output logic                                err_pulse,
    output hr_state_t                           dbg_state_o
);

    localparam int LINE_BITS = WORDS_PER_LINE * WORD_BITS;
    localparam int CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    hr_state_t                 state_q, state_d;
    logic [IDX_BITS-1:0]       init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]          lat_cnt_q, lat_cnt_d;
    logic                      acc_done_q, acc_done_d;
    logic                      err_q, err_d;

    logic [MSG_BITS-1:0]       req_msg_q, req_msg_d;
    logic [REQ_ID_BITS-1:0]    req_id_q, req_id_d;
    logic [LINE_ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic [WORDS_PER_LINE-1:0] req_mask_q, req_mask_d;
    logic [LINE_BITS-1:0]      req_line_q, req_line_d;

    logic [MSG_BITS-1:0]       rsp_msg_q, rsp_msg_d;
    logic [REQ_ID_BITS-1:0]    rsp_id_q, rsp_id_d;
    logic [LINE_ADDR_BITS-1:0] rsp_addr_q, rsp_addr_d;
    logic [WORDS_PER_LINE-1:0] rsp_mask_q, rsp_mask_d;
    logic [LINE_BITS-1:0]      rsp_line_q, rsp_line_d;

    logic [IDX_BITS-1:0]       st_index;
    logic                      st_rd_en;
    logic                      st_wr_en;
    logic [WORDS_PER_LINE-1:0] st_wmask;
    logic [LINE_BITS-1:0]      st_wdata;
    logic [LINE_BITS-1:0]      st_rdata;

    l2_home_store #(
        .WORD_BITS      (WORD_BITS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_BITS       (IDX_BITS)
    ) u_store (
        .clk     (clk),
        .index_i (st_index),
        .rd_en_i (st_rd_en),
        .wr_en_i (st_wr_en),
        .wmask_i (st_wmask),
        .wdata_i (st_wdata),
        .rdata_o (st_rdata)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        acc_done_d = acc_done_q;
        err_d      = 1'b0;
        req_msg_d  = req_msg_q;
        req_id_d   = req_id_q;
        req_addr_d = req_addr_q;
        req_mask_d = req_mask_q;
        req_line_d = req_line_q;
        rsp_msg_d  = rsp_msg_q;
        rsp_id_d   = rsp_id_q;
        rsp_addr_d = rsp_addr_q;
        rsp_mask_d = rsp_mask_q;
        rsp_line_d = rsp_line_q;
        // Tag bits are dropped: same low index bits alias to one line.
        st_index   = req_addr_q[IDX_BITS-1:0];
        st_rd_en   = 1'b0;
        st_wr_en   = 1'b0;
        st_wmask   = req_mask_q;
        st_wdata   = req_line_q;

        case (state_q)
            INIT: begin
                st_index   = init_cnt_q;
                st_wr_en   = 1'b1;
                st_wmask   = '1;
                st_wdata   = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_in_valid) begin
                    req_msg_d  = req_in_coh_msg;
                    req_id_d   = req_in_req_id;
                    req_addr_d = req_in_addr;
                    req_mask_d = req_in_word_mask;
                    req_line_d = req_in_line;
                    if (msg_supported(req_in_coh_msg)) begin
                        state_d    = MEM;
                        lat_cnt_d  = CNT_W'(MEM_LAT - 1);
                        acc_done_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            MEM: begin
                if (acc_done_q) begin
                    // Store read data from the previous edge is now valid.
                    rsp_msg_d  = msg_rsp(req_msg_q);
                    rsp_id_d   = req_id_q;
                    rsp_addr_d = req_addr_q;
                    rsp_mask_d = req_mask_q;
                    rsp_line_d = msg_reads(req_msg_q) ? st_rdata : '0;
                    state_d    = RSP;
                end else if (lat_cnt_q == '0) begin
                    st_rd_en   = 1'b1;
                    st_wr_en   = msg_writes(req_msg_q);
                    acc_done_d = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            RSP: begin
                if (rsp_out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            lat_cnt_q  <= '0;
            acc_done_q <= 1'b0;
            err_q      <= 1'b0;
            req_msg_q  <= '0;
            req_id_q   <= '0;
            req_addr_q <= '0;
            req_mask_q <= '0;
            req_line_q <= '0;
            rsp_msg_q  <= '0;
            rsp_id_q   <= '0;
            rsp_addr_q <= '0;
            rsp_mask_q <= '0;
            rsp_line_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            acc_done_q <= acc_done_d;
            err_q      <= err_d;
            req_msg_q  <= req_msg_d;
            req_id_q   <= req_id_d;
            req_addr_q <= req_addr_d;
            req_mask_q <= req_mask_d;
            req_line_q <= req_line_d;
            rsp_msg_q  <= rsp_msg_d;
            rsp_id_q   <= rsp_id_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_mask_q <= rsp_mask_d;
            rsp_line_q <= rsp_line_d;
        end
    end

    assign req_in_ready       = (state_q == IDLE);
    assign rsp_out_valid      = (state_q == RSP);
    assign rsp_out_coh_msg    = rsp_msg_q;
    assign rsp_out_req_id     = rsp_id_q;
    assign rsp_out_addr       = rsp_addr_q;
    assign rsp_out_word_mask  = rsp_mask_q;
    assign rsp_out_line       = rsp_line_q;
    assign rsp_out_invack_cnt = '0;
    assign err_pulse          = err_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_l2_home_responder.sv
module tb_l2_home_responder;
    import l2_home_responder_pkg::*;

    localparam int WB   = 32;
    localparam int WPL  = 4;
    localparam int LAB  = 28;
    localparam int RIB  = 4;
    localparam int LB   = WB * WPL;
    localparam int W    = MSG_BITS + RIB + LAB + WPL + LB + INVACK_CNT_BITS;
    localparam int TMO  = 200;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       req_in_valid = 1'b0;
    logic                       req_in_ready;
    logic [MSG_BITS-1:0]        req_in_coh_msg = '0;
    logic [RIB-1:0]             req_in_req_id = '0;
    logic [LAB-1:0]             req_in_addr = '0;
    logic [WPL-1:0]             req_in_word_mask = '0;
    logic [LB-1:0]              req_in_line = '0;
    logic                       rsp_out_valid;
    logic                       rsp_out_ready = 1'b1;
    logic [MSG_BITS-1:0]        rsp_out_coh_msg;
    logic [RIB-1:0]             rsp_out_req_id;
    logic [LAB-1:0]             rsp_out_addr;
    logic [WPL-1:0]             rsp_out_word_mask;
    logic [LB-1:0]              rsp_out_line;
    logic [INVACK_CNT_BITS-1:0] rsp_out_invack_cnt;
    logic                       err_pulse;
    hr_state_t                  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0] exp_q[$];

    l2_home_responder #(
        .WORD_BITS      (WB),
        .WORDS_PER_LINE (WPL),
        .LINE_ADDR_BITS (LAB),
        .IDX_BITS       (6),
        .REQ_ID_BITS    (RIB),
        .MEM_LAT        (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_in_valid       (req_in_valid),
        .req_in_ready       (req_in_ready),
        .req_in_coh_msg     (req_in_coh_msg),
        .req_in_req_id      (req_in_req_id),
        .req_in_addr        (req_in_addr),
        .req_in_word_mask   (req_in_word_mask),
        .req_in_line        (req_in_line),
        .rsp_out_valid      (rsp_out_valid),
        .rsp_out_ready      (rsp_out_ready),
        .rsp_out_coh_msg    (rsp_out_coh_msg),
        .rsp_out_req_id     (rsp_out_req_id),
        .rsp_out_addr       (rsp_out_addr),
        .rsp_out_word_mask  (rsp_out_word_mask),
        .rsp_out_line       (rsp_out_line),
        .rsp_out_invack_cnt (rsp_out_invack_cnt),
        .err_pulse          (err_pulse),
        .dbg_state_o        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rsp_obs();
        return {rsp_out_coh_msg, rsp_out_req_id, rsp_out_addr, rsp_out_word_mask,
                rsp_out_line, rsp_out_invack_cnt};
    endfunction

    // ---------------- drivers ----------------
    // Drives one request, waits for acceptance; returns the cycle count at
    // the accepting edge. Pushes the expected response when one is due.
    task automatic send_req(input logic [MSG_BITS-1:0] msg, input logic [RIB-1:0] id,
                            input logic [LAB-1:0] addr, input logic [WPL-1:0] mask,
                            input logic [LB-1:0] line, input bit expect_rsp,
                            input logic [MSG_BITS-1:0] exp_msg, input logic [LB-1:0] exp_line,
                            output int acc_cyc);
        int n;
        if (expect_rsp) exp_q.push_back({exp_msg, id, addr, mask, exp_line, {INVACK_CNT_BITS{1'b0}}});
        @(negedge clk);
        req_in_valid     = 1'b1;
        req_in_coh_msg   = msg;
        req_in_req_id    = id;
        req_in_addr      = addr;
        req_in_word_mask = mask;
        req_in_line      = line;
        n = 0;
        while (!req_in_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("accept_timeout", W'(n), W'(0));
        acc_cyc = cyc;
        @(posedge clk);
        #1 req_in_valid = 1'b0;
    endtask

    // Waits for the response, compares against the scoreboard head and
    // completes the handshake. lat counts negedges until valid is seen.
    task automatic get_rsp(output int lat);
        logic [W-1:0] exp;
        lat = 0;
        while (!rsp_out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= TMO) begin
            check("rsp_timeout", W'(lat), W'(0));
        end else if (exp_q.size() == 0) begin
            check("rsp_unexpected", W'(1), W'(0));
        end else begin
            exp = exp_q.pop_front();
            check("rsp_fields", rsp_obs(), exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic count_init(input string tag, output int valid_seen);
        int n;
        n = 0;
        valid_seen = 0;
        while (!req_in_ready && n < TMO) begin
            if (rsp_out_valid) valid_seen++;
            n++;
            @(negedge clk);
        end
        check(tag, W'(n), W'(64));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        word_t a, b, c, d, x;
        logic [RIB-1:0] id;
        logic [LB-1:0] line_c0a0, line_fca0;
        int acc0, acc1, lat, vs;

        a = $urandom(); b = $urandom(); c = $urandom(); d = $urandom();
        x = $urandom();
        line_c0a0 = {32'h0, c, 32'h0, a};
        line_fca0 = {32'hFF, c, 32'h0, a};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_fields", rsp_obs(), '0);
        check("reset_ready_valid_err", W'({req_in_ready, rsp_out_valid, err_pulse}), W'(0));
        rst = 1'b0;
        count_init("init_len", vs);
        check("init_no_valid", W'(vs), W'(0));

        // First read of a cleared line
        id = RIB'($urandom_range(0, 15));
        send_req(REQ_V, id, 28'h5, 4'b1111, '0, 1'b1, RSP_V, '0, acc0);
        get_rsp(lat);

        // Write then read
        id = RIB'($urandom_range(0, 15));
        send_req(REQ_WT, id, 28'h5, 4'b0101, {d, c, b, a}, 1'b1, RSP_WT, '0, acc0);
        get_rsp(lat);
        id = RIB'($urandom_range(0, 15));
        send_req(REQ_S, id, 28'h5, 4'b1111, '0, 1'b1, RSP_S, line_c0a0, acc0);
        get_rsp(lat);

        // Read-modify-write through an aliasing address
        id = RIB'($urandom_range(0, 15));
        send_req(REQ_Odata, id, 28'h45, 4'b1000, {32'hFF, x, x, x}, 1'b1, RSP_Odata, line_c0a0, acc0);
        get_rsp(lat);

        // Latency and back-to-back throughput
        id = RIB'($urandom_range(0, 15));
        send_req(REQ_V, id, 28'h5, 4'b0010, '0, 1'b1, RSP_V, line_fca0, acc0);
        get_rsp(lat);
        check("latency_negedges", W'(lat), W'(4));
        send_req(REQ_V, id, 28'h85, 4'b0001, '0, 1'b1, RSP_V, line_fca0, acc1);
        get_rsp(lat);
        check("throughput_cycles", W'(acc1 - acc0), W'(5));

        // REQ_O, REQ_WB with empty mask, then read back
        send_req(REQ_O, 4'h3, 28'h9, 4'b0011, {d, c, b, a}, 1'b1, RSP_O, '0, acc0);
        get_rsp(lat);
        send_req(REQ_WB, 4'h4, 28'h9, 4'b0000, {x, x, x, x}, 1'b1, RSP_WB_ACK, '0, acc0);
        get_rsp(lat);
        send_req(REQ_S, 4'h5, 28'h9, 4'b1111, '0, 1'b1, RSP_S, {32'h0, 32'h0, b, a}, acc0);
        get_rsp(lat);

        // Backpressure
        rsp_out_ready = 1'b0;
        send_req(REQ_V, 4'h6, 28'h5, 4'b1111, '0, 1'b1, RSP_V, line_fca0, acc0);
        lat = 0;
        while (!rsp_out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_ready", W'({rsp_out_valid, req_in_ready}), W'(2'b10));
            check("bp_fields_stable", rsp_obs(), exp_q[0]);
            @(negedge clk);
        end
        rsp_out_ready = 1'b1;
        get_rsp(lat);
        @(negedge clk);
        check("bp_after_handshake", W'({rsp_out_valid, req_in_ready}), W'(2'b01));

        // Unsupported opcode
        send_req(5'd31, 4'h7, 28'h5, 4'b1111, {x, x, x, x}, 1'b0, '0, '0, acc0);
        @(negedge clk);
        check("err_pulse_high", W'({err_pulse, req_in_ready}), W'(2'b11));
        vs = 0;
        @(negedge clk);
        check("err_pulse_single", W'(err_pulse), W'(0));
        for (int i = 0; i < 6; i++) begin
            if (rsp_out_valid) vs++;
            @(negedge clk);
        end
        check("err_no_rsp", W'(vs), W'(0));
        send_req(REQ_V, 4'h8, 28'h5, 4'b1111, '0, 1'b1, RSP_V, line_fca0, acc0);
        get_rsp(lat);

        // Reset while in MEM drops the request and re-clears the store
        send_req(REQ_V, 4'h9, 28'h5, 4'b1111, '0, 1'b0, '0, '0, acc0);
        @(negedge clk);
        check("state_mem", W'(dbg_state), W'(MEM));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_init("reinit_len", vs);
        check("reinit_no_valid", W'(vs), W'(0));
        send_req(REQ_V, 4'hA, 28'h5, 4'b1111, '0, 1'b1, RSP_V, '0, acc0);
        get_rsp(lat);

        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_home_responder.md
Name: l2_home_responder

Overview:
- Memory-side responder for the L2's outbound request channel (l2_req_out) and inbound response channel (l2_rsp_in). It is the home end of the Spandex request/response protocol.
- Accepts one Spandex request at a time, services it from a small word-maskable backing store, and returns the matching response.
- Used as the home node in L2 unit/system benches and in small single-L2 configurations without an LLC. No forwarding; there is no fwd channel.

Parameters:
- WORD_BITS, 32, bits per word
- WORDS_PER_LINE, 4, words per line; also the word_mask width
- LINE_ADDR_BITS, 28, line address width
- IDX_BITS, 6, backing-store index width (2^IDX_BITS lines; index = addr[IDX_BITS-1:0])
- REQ_ID_BITS, 4, requestor id width
- MEM_LAT, 2, cycles spent in MEM state (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_in_valid  in  1  request valid (driven from L2 l2_req_out_valid)
- req_in_ready  out  1  request accepted when valid&ready
- req_in_coh_msg  in  MSG_BITS  Spandex request type (REQ_V, REQ_S, REQ_WT, REQ_O, REQ_Odata, REQ_WB)
- req_in_req_id  in  REQ_ID_BITS  requestor id
- req_in_addr  in  LINE_ADDR_BITS  line address
- req_in_word_mask  in  WORDS_PER_LINE  words targeted
- req_in_line  in  WORDS_PER_LINE*WORD_BITS  write data
- rsp_out_valid  out  1  response valid (to L2 l2_rsp_in_valid)
- rsp_out_ready  in  1  response consumed when valid&ready
- rsp_out_coh_msg  out  MSG_BITS  response type
- rsp_out_req_id  out  REQ_ID_BITS  echoed requestor id
- rsp_out_addr  out  LINE_ADDR_BITS  echoed line address
- rsp_out_word_mask  out  WORDS_PER_LINE  echoed mask
- rsp_out_line  out  WORDS_PER_LINE*WORD_BITS  read data (zero for no-data responses)
- rsp_out_invack_cnt  out  INVACK_CNT_BITS  always 0
- err_pulse  out  1  one-cycle pulse on an unsupported coh_msg

Behaviour:
- Interface is fixed: one clock, clk; rst is synchronous, active-high.
- FSM states: INIT, IDLE, MEM, RSP.
- Reset:
  - FSM enters INIT; init counter = 0.
  - Outputs: req_in_ready=0, rsp_out_valid=0, err_pulse=0, all rsp_out_* fields = 0.
  - Reset asserted mid-transaction drops the transaction; no response is emitted.
- INIT:
  - Writes zero to line[init_cnt], one line per cycle.
  - After line 2^IDX_BITS-1 → IDLE. INIT lasts exactly 2^IDX_BITS cycles.
  - req_in_ready=0 throughout.
- IDLE:
  - req_in_ready=1 (combinational from state only, never from valid).
  - On valid&ready: latch all req_in fields, then:
    - supported msg → MEM, with latency counter = MEM_LAT-1
    - unsupported msg → err_pulse=1 for the following cycle, stay IDLE, no response
- MEM:
  - Counter decrements each cycle. When it is 0: perform the store access and load the response registers → RSP.
  - Accept-to-rsp_out_valid latency is MEM_LAT+1 cycles.
- Store access per coh_msg:
  - REQ_V, REQ_S: read the line. rsp = RSP_V / RSP_S. line = full stored line; masked-out words are still driven.
  - REQ_Odata: read, then masked write. rsp = RSP_Odata. line = data before the write.
  - REQ_WT: masked write. rsp = RSP_WT, line=0.
  - REQ_O: masked write. rsp = RSP_O, line=0.
  - REQ_WB: masked write. rsp = RSP_WB_ACK, line=0.
  - Masked write: word w is updated iff word_mask[w]. word_mask=0 leaves the line unchanged but still produces a response.
- RSP:
  - rsp_out_valid=1; all fields held stable until ready.
  - On ready → IDLE. The next request can be accepted on the cycle after the handshake; a new request is never accepted in the same cycle.
- Ordering and hazards:
  - Single outstanding request, so a write is always visible to the next read, including same-index aliasing across different tags.
  - The tag is not stored: addresses with equal low IDX_BITS alias by design.

Decomposition:
- Shared package (spandex_types/consts): reuse the existing mix_msg_t encodings for the REQ_*/RSP_* opcodes, plus MSG_BITS, INVACK_CNT_BITS and line_t/word_t.
- New package entry: the state enum hr_state_t {INIT, IDLE, MEM, RSP}.
- One sub-module: l2_home_store. It holds the 2^IDX_BITS×line register array with synchronous read and per-word write enable; the FSM drives its index, wdata and wmask.

Test Plan:
- Reset then idle:
  - req_in_ready stays 0 for exactly 64 cycles, then goes 1.
  - REQ_V to addr 0x5 returns RSP_V, line=0, req_id echoed, invack_cnt=0.
- Write then read:
  - REQ_WT addr 0x5, mask 4'b0101, line={w3..w0}={D,C,B,A} → RSP_WT, line=0.
  - Then REQ_S addr 0x5 → RSP_S, line={0,C,0,A}.
- Read-modify-write:
  - REQ_Odata addr 0x45 (aliases index 5), mask 4'b1000, w3=0xFF → RSP_Odata with the old line {0,C,0,A}.
  - A subsequent REQ_V returns {0xFF,C,0,A}.
- Backpressure:
  - Hold rsp_out_ready=0 for 10 cycles → valid and all fields stable, req_in_ready=0.
  - Release → one handshake, then IDLE.
- Latency and throughput:
  - With MEM_LAT=2 and ready tied high, rsp_out_valid rises 3 cycles after accept.
  - Back-to-back requests complete every 5 cycles.
- Errors and reset:
  - Unsupported coh_msg → single err_pulse, no rsp_out_valid, next request serviced normally.
  - rst asserted while in MEM → no response, INIT re-runs, memory reads back 0.
